// File: rtl/apb_cmd_master.sv
// Command-queued APB requester: buffers read/write commands in a small FIFO and
// issues each as a SETUP/ACCESS transfer, returning one response per command.
module apb_cmd_master #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // Command port: a command transfers on any rising edge where cmd_valid && cmd_ready.
    // cmd_ready depends only on the registered FIFO count, never on cmd_valid.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic [1:0]        fsm_state
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    // Bit 0 is PSEL and bit 1 is PENABLE, so both come straight from flops.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b11;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata [DEPTH];
    logic              fifo_write [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [TW-1:0]     wait_cnt;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              xfer_done;
    logic              xfer_abort;
    logic              xfer_end;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign xfer_done  = (state == ST_ACCESS) && PREADY;
    assign xfer_abort = (state == ST_ACCESS) && !PREADY && (wait_cnt == TW'(TIMEOUT - 1));
    assign xfer_end   = xfer_done || xfer_abort;
    assign pop        = !fifo_empty && ((state == ST_IDLE) || xfer_end);

    assign PSEL      = state[0];
    assign PENABLE   = state[1];
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign fsm_state = state;

    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
            fifo_write[wr_ptr] <= cmd_write;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= xfer_end;
            rsp_err   <= xfer_abort;
            rsp_rdata <= (xfer_done && !PWRITE) ? PRDATA : '0;
            // Address/control are only reloaded on a pop, so they hold through ACCESS.
            if (pop) begin
                PADDR  <= fifo_addr[rd_ptr];
                PWRITE <= fifo_write[rd_ptr];
                PWDATA <= fifo_write[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_SETUP;
                end
                ST_SETUP: begin
                    state    <= ST_ACCESS;
                    wait_cnt <= '0;
                end
                ST_ACCESS: begin
                    if (xfer_end) state <= pop ? ST_SETUP : ST_IDLE;
                    else          wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: transaction-level model, reactive APB
// slave with scripted wait states, directed scenarios and a randomized run.
module tb_apb_cmd_master;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                wt;
    } cmd_t;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic [1:0]        fsm_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int forced_wait = 0;

    cmd_t              cmd_q[$];
    cmd_t              cur;
    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W-1:0] model_mem [8];
    logic [DATA_W-1:0] slave_mem [8];
    int                fifo_cnt;
    int                exp_phase;
    int                acc_n;
    logic              rsp_due;
    logic              pend;
    logic              pend_w;
    logic [ADDR_W-1:0] pend_a;
    logic [DATA_W-1:0] pend_d;
    int                pend_wt;

    int              setup_log[$];
    int              acc_log[$];
    int              rsp_cyc_log[$];
    logic [DATA_W:0] rsp_log[$];

    apb_cmd_master #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
    endtask

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [63:0] qr(input logic [DATA_W:0] q[$], input int i);
        return (i < q.size()) ? 64'(q[i]) : '1;
    endfunction

    task automatic clear_logs();
        setup_log.delete();
        acc_log.delete();
        rsp_cyc_log.delete();
        rsp_log.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Called shortly after a rising edge; returns the edge number that accepted it.
    task automatic send(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int acc);
        logic ok;
        int   guard;
        guard     = 0;
        acc       = -1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        forever begin
            @(negedge PCLK);
            ok = cmd_ready;
            @(posedge PCLK);
            #1;
            if (ok) begin
                acc = cyc;
                break;
            end
            guard++;
            if (guard > 300) begin
                fail_bound("send_accept");
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge PCLK);
            #1;
            n++;
        end while ((exp_q.size() != 0 || busy) && n < budget);
        if (n >= budget) fail_bound("wait_idle");
        @(posedge PCLK);
        #1;
    endtask

    // ---------------- model, slave and compare process ----------------
    always @(negedge PCLK) begin
        int              obs;
        int              r;
        logic            ending;
        logic [DATA_W:0] e;
        cmd_t            c;
        if (!PRESET) begin
            chk("rst_psel", PSEL, 0);
            chk("rst_penable", PENABLE, 0);
            chk("rst_pwrite", PWRITE, 0);
            chk("rst_paddr", PADDR, 0);
            chk("rst_pwdata", PWDATA, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
            cmd_q.delete();
            exp_q.delete();
            fifo_cnt  = 0;
            exp_phase = 0;
            acc_n     = 0;
            rsp_due   = 1'b0;
            pend      = 1'b0;
            for (int i = 0; i < 8; i++) begin
                model_mem[i] = '0;
                slave_mem[i] = '0;
            end
            PREADY = 1'b0;
            PRDATA = '0;
        end else begin
            // A command accepted at the last edge: its response is fixed now, in order.
            if (pend) begin
                c.w  = pend_w;
                c.a  = pend_a;
                c.d  = pend_d;
                c.wt = pend_wt;
                if (c.wt >= TIMEOUT) e = {1'b1, {DATA_W{1'b0}}};
                else if (c.w) begin
                    model_mem[c.a[4:2]] = c.d;
                    e = {1'b0, {DATA_W{1'b0}}};
                end else e = {1'b0, model_mem[c.a[4:2]]};
                cmd_q.push_back(c);
                exp_q.push_back(e);
                fifo_cnt++;
            end

            obs = PSEL ? (PENABLE ? 2 : 1) : 0;
            chk("psel", PSEL, exp_phase != 0);
            chk("penable", PENABLE, exp_phase == 2);
            chk("rsp_valid", rsp_valid, rsp_due);
            if (rsp_valid) begin
                rsp_log.push_back({rsp_err, rsp_rdata});
                rsp_cyc_log.push_back(cyc);
                if (exp_q.size() == 0) fail_bound("rsp_unexpected");
                else chk("rsp_data", {rsp_err, rsp_rdata}, exp_q.pop_front());
            end

            if (obs == 1) begin
                setup_log.push_back(cyc);
                if (cmd_q.size() == 0) fail_bound("setup_without_cmd");
                else begin
                    cur = cmd_q.pop_front();
                    fifo_cnt--;
                end
                acc_n = 0;
                chk("setup_paddr", PADDR, cur.a);
                chk("setup_pwrite", PWRITE, cur.w);
                chk("setup_pwdata", PWDATA, cur.w ? cur.d : '0);
            end else if (obs == 2) begin
                acc_n++;
                chk("access_paddr", PADDR, cur.a);
                chk("access_pwrite", PWRITE, cur.w);
                chk("access_pwdata", PWDATA, cur.w ? cur.d : '0);
            end
            chk("cmd_ready", cmd_ready, fifo_cnt != DEPTH);
            chk("busy", busy, (obs != 0) || (fifo_cnt != 0));

            // Slave: PREADY on the (wt+1)-th ACCESS cycle, or never when wt >= TIMEOUT.
            ending = 1'b0;
            PREADY = 1'b0;
            PRDATA = $urandom();
            if (obs == 2) begin
                if (cur.wt < TIMEOUT && acc_n == cur.wt + 1) begin
                    PREADY = 1'b1;
                    ending = 1'b1;
                    if (cur.w) slave_mem[PADDR[4:2]] = PWDATA;
                    else PRDATA = slave_mem[PADDR[4:2]];
                end else if (acc_n == TIMEOUT) ending = 1'b1;
                if (ending) acc_log.push_back(acc_n);
            end

            case (obs)
                0:       exp_phase = (fifo_cnt != 0) ? 1 : 0;
                1:       exp_phase = 2;
                default: exp_phase = ending ? ((fifo_cnt != 0) ? 1 : 0) : 2;
            endcase
            rsp_due = ending;

            pend   = cmd_valid && cmd_ready;
            pend_w = cmd_write;
            pend_a = cmd_addr;
            pend_d = cmd_wdata;
            if (forced_wait >= 0) pend_wt = forced_wait;
            else begin
                r = $urandom_range(0, 9);
                if (r == 0)      pend_wt = TIMEOUT + 4;
                else if (r == 1) pend_wt = TIMEOUT - 1;
                else             pend_wt = $urandom_range(0, 3);
            end
        end
    end

    // ---------------- scenarios ----------------
    initial begin
        int acc;
        int acc_a[6];
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRESET    = 1'b0;
        repeat (3) @(posedge PCLK);
        #3 PRESET = 1'b1;
        @(posedge PCLK);
        #1;

        // Single zero-wait write.
        clear_logs();
        forced_wait = 0;
        send(1'b1, 32'h0, 32'd5, acc);
        wait_idle(100);
        chk("t1_setup_cycle", qi(setup_log, 0), acc + 1);
        chk("t1_rsp_cycle", qi(rsp_cyc_log, 0), acc + 3);
        chk("t1_access_len", qi(acc_log, 0), 1);
        chk("t1_rsp", qr(rsp_log, 0), 0);

        // Write then read, back-to-back.
        clear_logs();
        send(1'b1, 32'h4, 32'd7, acc);
        send(1'b0, 32'h4, 32'd0, acc);
        wait_idle(100);
        chk("t2_read_data", qr(rsp_log, 1), 7);
        chk("t2_no_gap", qi(setup_log, 1), qi(setup_log, 0) + 2);

        // Wait states, then the last-cycle PREADY boundary.
        clear_logs();
        send(1'b1, 32'h8, 32'd35, acc);
        forced_wait = 3;
        send(1'b0, 32'h8, 32'd0, acc);
        forced_wait = TIMEOUT - 1;
        send(1'b0, 32'h8, 32'd0, acc);
        wait_idle(200);
        chk("t3_access_len", qi(acc_log, 1), 4);
        chk("t3_read_data", qr(rsp_log, 1), 35);
        chk("t3_edge_len", qi(acc_log, 2), TIMEOUT);
        chk("t3_edge_rsp", qr(rsp_log, 2), 35);

        // Timeout, then normal traffic resumes.
        clear_logs();
        forced_wait = 100;
        send(1'b0, 32'hC, 32'd0, acc);
        forced_wait = 0;
        send(1'b1, 32'hC, 32'd9, acc);
        send(1'b0, 32'hC, 32'd0, acc);
        wait_idle(200);
        chk("t4_abort_len", qi(acc_log, 0), TIMEOUT);
        chk("t4_abort_rsp", qr(rsp_log, 0), {1'b1, 32'h0});
        chk("t4_after_rsp", qr(rsp_log, 2), 9);

        // FIFO full behind a stalled transfer.
        clear_logs();
        forced_wait = 8;
        send(1'b0, 32'h0, 32'd0, acc_a[0]);
        forced_wait = 2;
        for (int i = 1; i < 6; i++) send(1'b1, 32'(i * 4), 32'(100 + i), acc_a[i]);
        wait_idle(300);
        chk("t5_fill_consecutive", acc_a[4], acc_a[1] + 3);
        chk("t5_fifth_after_pop", acc_a[5], qi(setup_log, 1) + 1);
        chk("t5_rsp_count", rsp_log.size(), 6);

        // Asynchronous reset mid-ACCESS with two commands queued.
        forced_wait = 10;
        for (int i = 0; i < 3; i++) send(1'b1, 32'(i * 4), 32'(200 + i), acc);
        acc = 0;
        while (!PENABLE && acc < 30) begin
            @(negedge PCLK);
            acc++;
        end
        if (acc >= 30) fail_bound("t6_reach_access");
        @(posedge PCLK);
        #3;
        chk("t6_pre_psel", PSEL, 1);
        PRESET = 1'b0;
        #1;
        chk("t6_async_psel", PSEL, 0);
        chk("t6_async_penable", PENABLE, 0);
        chk("t6_async_rsp", rsp_valid, 0);
        repeat (2) @(negedge PCLK);
        #2 PRESET = 1'b1;
        @(negedge PCLK);
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        repeat (10) @(negedge PCLK);
        @(posedge PCLK);
        #1;

        // Randomized traffic.
        forced_wait = -1;
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge PCLK);
                #1;
            end
            send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), $urandom(), acc);
        end
        wait_idle(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
